// File: rtl/ram_arb.sv
// ram_arb: serializes writer, reader and host accesses onto the single-port frame RAM,
// fixed priority writer > reader > host with host anti-starvation and writer-late flag.
module ram_arb #(
   parameter int RD_LAT      = 1,
   parameter int HST_MAXWAIT = 15,
   parameter int WR_MAXWAIT  = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_req,
   output logic        wr_ack,
   input  logic [12:0] wr_addr,
   input  logic [7:0]  wr_data,
   input  logic        rd_req,
   output logic        rd_ack,
   input  logic [12:0] rd_addr,
   output logic [7:0]  rd_data,
   input  logic        hst_req,
   input  logic        hst_we,
   output logic        hst_ack,
   input  logic [12:0] hst_addr,
   input  logic [7:0]  hst_wdata,
   output logic [7:0]  hst_rdata,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [12:0] ram_addr,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   input  logic        err_clr,
   output logic        err_wr_late
);
   localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, RWAIT = 2'd2, RDONE = 2'd3;
   localparam logic [1:0] G_WR = 2'd0, G_RD = 2'd1, G_HST = 2'd2;
   logic [1:0]  r_state, r_gnt, r_lat;
   logic [3:0]  r_hst_cnt, r_wr_cnt;
   logic [1:0]  w_next, w_gnt;
   logic [12:0] w_addr;
   logic [7:0]  w_wdata;
   logic        w_idle, w_sel, w_we, w_rdone, w_wr_wait, w_hst_wait, w_wr_set;
   always_comb begin
      w_idle     = r_state == IDLE;
      w_sel      = w_idle && (wr_req || rd_req || hst_req);
      w_gnt      = (hst_req && r_hst_cnt == 4'(HST_MAXWAIT)) ? G_HST : wr_req ? G_WR : rd_req ? G_RD : G_HST;
      w_we       = w_gnt == G_WR || (w_gnt == G_HST && hst_we);
      w_addr     = w_gnt == G_WR ? wr_addr : w_gnt == G_RD ? rd_addr : hst_addr;
      w_wdata    = w_gnt == G_WR ? wr_data : hst_wdata;
      w_rdone    = r_state == RWAIT && r_lat == 2'd0;
      // a requester being served, or granted right now, is not waiting
      w_wr_wait  = wr_req && !((!w_idle && r_gnt == G_WR) || (w_sel && w_gnt == G_WR));
      w_hst_wait = hst_req && !((!w_idle && r_gnt == G_HST) || (w_sel && w_gnt == G_HST));
      w_wr_set   = w_wr_wait && r_wr_cnt >= 4'(WR_MAXWAIT - 1);
      w_next     = w_idle ? (w_sel ? ACC : IDLE) :
                   r_state == ACC ? (ram_we ? IDLE : RWAIT) :
                   r_state == RWAIT ? (w_rdone ? RDONE : RWAIT) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_gnt       <= G_WR;
         r_lat       <= 2'd0;
         r_hst_cnt   <= 4'd0;
         r_wr_cnt    <= 4'd0;
         ram_ce      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= 13'd0;
         ram_wdata   <= 8'd0;
         wr_ack      <= 1'b0;
         rd_ack      <= 1'b0;
         hst_ack     <= 1'b0;
         rd_data     <= 8'd0;
         hst_rdata   <= 8'd0;
         err_wr_late <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_lat       <= r_state == ACC ? 2'(RD_LAT - 1) : r_lat - 2'd1;
         ram_ce      <= w_sel;
         ram_we      <= w_sel && w_we;
         wr_ack      <= w_sel && w_gnt == G_WR;
         rd_ack      <= w_rdone && r_gnt == G_RD;
         hst_ack     <= (w_sel && w_we && w_gnt == G_HST) || (w_rdone && r_gnt == G_HST);
         r_hst_cnt   <= w_hst_wait ? (r_hst_cnt == 4'(HST_MAXWAIT) ? r_hst_cnt : r_hst_cnt + 4'd1) : 4'd0;
         r_wr_cnt    <= w_wr_wait ? (r_wr_cnt == 4'(WR_MAXWAIT) ? r_wr_cnt : r_wr_cnt + 4'd1) : 4'd0;
         err_wr_late <= w_wr_set || (err_wr_late && !err_clr);
         if (w_sel) begin
            r_gnt    <= w_gnt;
            ram_addr <= w_addr;
            if (w_we)
               ram_wdata <= w_wdata;
         end
         if (w_rdone && r_gnt == G_RD)
            rd_data <= ram_rdata;
         if (w_rdone && r_gnt == G_HST)
            hst_rdata <= ram_rdata;
      end
   end
endmodule
